sram_like_resp: RTL and testbench
=================================

SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, word-address width (backing store of 2^ADDR_W 32-bit words).
REQ-002 The block SHALL have parameter LAT, default 2, range 1..8, cycles from address acceptance to data_ok.
REQ-003 The block SHALL have parameter DEPTH, default 2, range 1..4, maximum outstanding accepted requests.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req  in  1  request valid from initiator.
REQ-007 wr  in  1  1 = write, 0 = read.
REQ-008 size  in  2  0 = byte, 1 = half, 2 = word; informational only.
REQ-009 wstrb  in  4  byte write enables; used only when wr=1.
REQ-010 addr  in  32  byte address; bits [ADDR_W+1:2] index the store.
REQ-011 wdata  in  32  write data, byte lanes pre-replicated by initiator.
REQ-012 addr_ok  out  1  request accepted this cycle when req & addr_ok.
REQ-013 data_ok  out  1  one-cycle response pulse, in acceptance order.
REQ-014 rdata  out  32  read data, valid only with data_ok.

Function
REQ-015 The block SHALL accept a request in any cycle where req & addr_ok.
REQ-016 The block SHALL drive addr_ok = (outstanding count < DEPTH), from registered count only, with no same-cycle retire bypass.
REQ-017 On an accepted write, the block SHALL update each store byte i where wstrb[i]=1 at that clock edge; other bytes are unchanged.
REQ-018 On an accepted read, the block SHALL capture the store word at that edge, so later writes never alter an already-accepted read.
REQ-019 Each accepted request SHALL enter an in-order pending queue with {is_read, data, down-counter loaded with LAT-1}.
REQ-020 Every non-head and head entry counter SHALL decrement by 1 per cycle while nonzero.
REQ-021 The block SHALL assert data_ok for exactly one cycle when the head counter is 0, then pop the head, so data_ok rises exactly LAT cycles after acceptance.
REQ-022 rdata SHALL equal the captured word for a read head and 32'h0 for a write head or when data_ok=0.
REQ-023 data_ok SHALL have no back-pressure; the initiator always consumes it.
REQ-024 Simultaneous accept and pop SHALL leave the count unchanged; the full queue is never overrun and an empty queue is never popped.
REQ-025 Address bits above ADDR_W+1 SHALL be ignored (aliasing), addr[1:0] SHALL not affect indexing, and no alignment check SHALL be made.
REQ-026 At back-to-back acceptance with DEPTH>=LAT, the block SHALL sustain one request per cycle.

Reset
REQ-027 While reset=1, the block SHALL drive addr_ok=0, data_ok=0, and rdata=0, clear the queue, and reset the count to 0.
REQ-028 Reset asserted mid-operation SHALL discard all pending responses, and no data_ok SHALL follow for them.
REQ-029 Store contents SHALL NOT be reset.
REQ-030 After reset deasserts, addr_ok SHALL be 1 on the first cycle.

Configuration
REQ-031 The block SHALL implement macro SRAM_RESP_RANDOM_STALL_EN.
REQ-032 With SRAM_RESP_RANDOM_STALL_EN defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1; steps every cycle) SHALL gate addr_ok, so addr_ok = occupancy condition & lfsr[0].
REQ-033 Without SRAM_RESP_RANDOM_STALL_EN, no LFSR SHALL exist and addr_ok SHALL be as in REQ-016.

Structure
REQ-034 Shared package sram_like_pkg SHALL hold the size encodings (SIZE_B/H/W), default ADDR_W/LAT/DEPTH, and the LFSR seed.
REQ-035 One sub-module, resp_fifo, SHALL implement the pending queue with its counters, head-ready flag, and count; the top holds the store, handshake, and optional LFSR.

Verification
REQ-036 Stimulus: LAT=2; write addr 0x10, wdata 0x11223344, wstrb 4'hF; then read 0x10 -> data_ok 2 cycles after each acceptance; read rdata=0x11223344.
REQ-037 Stimulus: wstrb=4'b0100, wdata 0xAAAAAAAA to 0x10 over 0x11223344, then read -> rdata=0x11AA3344.
REQ-038 Stimulus: DEPTH=2, LAT=4, req held with 5 reads -> addr_ok low after 2 acceptances, resumes after first data_ok; responses return in order, none lost.
REQ-039 Stimulus: read 0x20 accepted, then write 0x20 next cycle -> read returns the old value.
REQ-040 Stimulus: reset pulse with 2 pending -> no data_ok follows; addr_ok=1 the cycle after release; store contents survive.
REQ-041 Stimulus: SRAM_RESP_RANDOM_STALL_EN defined, 1000 random requests -> addr_ok stalls observed; scoreboard matches all rdata.

Source files
------------

// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like responder: size encodings, default
// geometry, the queued response record and the stall LFSR seed/step.
package sram_like_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_LAT    = 2;
    localparam int DEF_DEPTH  = 2;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
    } resp_t;

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting toward the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order pending-response queue: slot 0 is the head, every live slot counts
// down towards zero, and the head is ready once its counter reaches zero.
module resp_fifo
    import sram_like_pkg::*;
#(
    parameter int LAT   = DEF_LAT,
    parameter int DEPTH = DEF_DEPTH,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  resp_t            push_data,
    input  logic             pop,
    output logic             head_ready,
    output resp_t            head,
    output logic [OCC_W-1:0] count
);

    localparam int               CNT_W    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    logic [CNT_W-1:0] cnt     [DEPTH];
    logic [CNT_W-1:0] cnt_nxt [DEPTH];
    resp_t            ent     [DEPTH];
    resp_t            ent_nxt [DEPTH];
    logic [OCC_W-1:0] wr_slot;

    // NOTE: every always_comb output gets a default before any branch, so no latch can form.
    always_comb begin
        wr_slot = pop ? count - OCC_W'(1) : count;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt[i] = cnt[i];
            ent_nxt[i] = ent[i];
            if (pop) begin
                cnt_nxt[i] = cnt[(i + 1 < DEPTH) ? i + 1 : i];
                ent_nxt[i] = ent[(i + 1 < DEPTH) ? i + 1 : i];
            end
            if (cnt_nxt[i] != '0) begin
                cnt_nxt[i] = cnt_nxt[i] - CNT_W'(1);
            end
            // A fresh entry lands behind the survivors and starts at LAT-1.
            if (push && (OCC_W'(i) == wr_slot)) begin
                cnt_nxt[i] = CNT_LOAD;
                ent_nxt[i] = push_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            count <= count + OCC_W'(push) - OCC_W'(pop);
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // NOTE: payload slots are qualified by count, so they are deliberately left without reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent[i] <= ent_nxt[i];
        end
    end

    assign head_ready = (count != '0) && (cnt[0] == '0);
    assign head       = ent[0];

endmodule

// File: rtl/sram_like_resp.sv
// SRAM-like slave with fixed response latency and bounded outstanding requests.
// Optional macro SRAM_RESP_RANDOM_STALL_EN gates addr_ok with a free-running LFSR.
module sram_like_resp
    import sram_like_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LAT    = DEF_LAT,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [31:0]       store [2**ADDR_W];
    logic [ADDR_W-1:0] word_idx;
    logic [OCC_W-1:0]  count;
    logic              occ_ok;
    logic              accept;
    logic              unused_bits;
    resp_t             push_data;
    resp_t             head;

    // Upper address bits alias and the byte offset never affects indexing.
    assign word_idx    = addr[ADDR_W+1:2];
    assign unused_bits = ^{size, addr[1:0], addr[31:ADDR_W+2]};

    assign occ_ok = (count < OCC_W'(DEPTH));

`ifdef SRAM_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign addr_ok = ~reset & occ_ok & lfsr[0];
`else
    assign addr_ok = ~reset & occ_ok;
`endif

    assign accept = req & addr_ok;

    // Reads snapshot the word at acceptance so later writes cannot leak in.
    always_comb begin
        push_data.is_read = ~wr;
        push_data.data    = wr ? 32'h0 : store[word_idx];
    end

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    store[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    resp_fifo #(
        .LAT   (LAT),
        .DEPTH (DEPTH),
        .OCC_W (OCC_W)
    ) u_resp_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_data  (push_data),
        .pop        (data_ok),
        .head_ready (data_ok),
        .head       (head),
        .count      (count)
    );

    assign rdata = (data_ok && head.is_read) ? head.data : 32'h0;

endmodule

// File: tb/tb_sram_like_resp.sv
// Self-checking bench for sram_like_resp: two instances (LAT2/DEPTH3 and LAT4/DEPTH2)
// checked every cycle against a due-time scoreboard plus directed scenario checks.
module tb_sram_like_resp;

    localparam int LAT0 = 2, DEPTH0 = 3;
    localparam int LAT1 = 4, DEPTH1 = 2;

    typedef struct packed {
        int          due;
        logic        is_read;
        logic [31:0] data;
    } pend_t;

    logic        clk;
    logic        reset;
    logic        req     [2];
    logic        wr      [2];
    logic [1:0]  size    [2];
    logic [3:0]  wstrb   [2];
    logic [31:0] addr    [2];
    logic [31:0] wdata   [2];
    logic        addr_ok [2];
    logic        data_ok [2];
    logic [31:0] rdata   [2];

    // Reference model: expected store, pending responses with due cycle, LFSR.
    logic [31:0] mem_m [2][1024];
    pend_t       pq    [2][16];
    int          ph    [2];
    int          pn    [2];
    logic [15:0] lfsr_m [2];
    bit          acc_last [2];
    int          cyc;
    int          n_cmp;
    int          n_bad;

    sram_like_resp #(.ADDR_W(10), .LAT(LAT0), .DEPTH(DEPTH0)) dut0 (
        .clk(clk), .reset(reset), .req(req[0]), .wr(wr[0]), .size(size[0]),
        .wstrb(wstrb[0]), .addr(addr[0]), .wdata(wdata[0]),
        .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0])
    );

    sram_like_resp #(.ADDR_W(10), .LAT(LAT1), .DEPTH(DEPTH1)) dut1 (
        .clk(clk), .reset(reset), .req(req[1]), .wr(wr[1]), .size(size[1]),
        .wstrb(wstrb[1]), .addr(addr[1]), .wdata(wdata[1]),
        .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1])
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int depth_of(input int i);
        return (i == 0) ? DEPTH0 : DEPTH1;
    endfunction

    // One clock: compare all outputs with the model, then advance model across the edge.
    task automatic step();
        bit          acc [2];
        bit          pop [2];
        logic        exp_ok;
        logic        exp_dok;
        logic [31:0] exp_rd;
        int          slot;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                pn[i]     = 0;
                lfsr_m[i] = 16'hACE1;
            end
            exp_ok = !reset && (pn[i] < depth_of(i));
`ifdef SRAM_RESP_RANDOM_STALL_EN
            exp_ok = exp_ok && lfsr_m[i][0];
`endif
            exp_dok = !reset && (pn[i] > 0) && (pq[i][ph[i]].due == cyc);
            exp_rd  = (exp_dok && pq[i][ph[i]].is_read) ? pq[i][ph[i]].data : 32'h0;
            n_cmp++;
            if (addr_ok[i] !== exp_ok) begin
                n_bad++;
                $display("FAIL addr_ok dut%0d cyc %0d: got %b want %b", i, cyc, addr_ok[i], exp_ok);
            end
            n_cmp++;
            if (data_ok[i] !== exp_dok) begin
                n_bad++;
                $display("FAIL data_ok dut%0d cyc %0d: got %b want %b", i, cyc, data_ok[i], exp_dok);
            end
            n_cmp++;
            if (rdata[i] !== exp_rd) begin
                n_bad++;
                $display("FAIL rdata dut%0d cyc %0d: got %h want %h", i, cyc, rdata[i], exp_rd);
            end
            acc[i]      = (req[i] === 1'b1) && exp_ok;
            pop[i]      = exp_dok;
            acc_last[i] = acc[i];
        end
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                if (pop[i]) begin
                    ph[i] = (ph[i] + 1) % 16;
                    pn[i]--;
                end
                if (acc[i]) begin
                    slot = (ph[i] + pn[i]) % 16;
                    pq[i][slot].due     = cyc + lat_of(i) - 1;
                    pq[i][slot].is_read = !wr[i];
                    pq[i][slot].data    = wr[i] ? 32'h0 : mem_m[i][addr[i][11:2]];
                    pn[i]++;
                    if (wr[i]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb[i][b]) mem_m[i][addr[i][11:2]][8*b +: 8] = wdata[i][8*b +: 8];
                        end
                    end
                end
                lfsr_m[i] = {lfsr_m[i][14:0], lfsr_m[i][15] ^ lfsr_m[i][13] ^ lfsr_m[i][12] ^ lfsr_m[i][10]};
            end
        end
        @(negedge clk);
    endtask

    // Present one request and hold it until accepted (bounded), then drop req.
    task automatic issue(input int i, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        int k;
        req[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d; wstrb[i] = s; size[i] = 2'd2;
        k = 0;
        do begin
            step();
            k++;
        end while (!acc_last[i] && k < 64);
        if (!acc_last[i]) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout dut%0d: addr %h never accepted", i, a);
        end
        req[i] = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic test_reset();
        idle_steps(3);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (addr_ok[i] !== 1'b0 || data_ok[i] !== 1'b0 || rdata[i] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_outputs dut%0d: got aok %b dok %b rd %h want 0 0 0",
                         i, addr_ok[i], data_ok[i], rdata[i]);
            end
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (addr_ok[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_release_aok dut%0d: got %b want 1", i, addr_ok[i]);
            end
        end
        step();
    endtask

    task automatic test_basic();
        issue(0, 1'b1, 32'h10, 32'h11223344, 4'hF);
        n_cmp++;
        if (data_ok[0] !== 1'b0) begin
            n_bad++; $display("FAIL basic_wr_early: data_ok got %b want 0", data_ok[0]);
        end
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        n_cmp++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== 32'h0) begin
            n_bad++; $display("FAIL basic_wr_resp: got dok %b rd %h want 1 0", data_ok[0], rdata[0]);
        end
        step();
        n_cmp++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== 32'h11223344) begin
            n_bad++; $display("FAIL basic_rd_resp: got dok %b rd %h want 1 11223344", data_ok[0], rdata[0]);
        end
        idle_steps(2);
    endtask

    task automatic test_strobe();
        issue(0, 1'b1, 32'h10, 32'hAAAAAAAA, 4'b0100);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        step();
        n_cmp++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== 32'h11AA3344) begin
            n_bad++; $display("FAIL strobe_merge: got dok %b rd %h want 1 11aa3344", data_ok[0], rdata[0]);
        end
        idle_steps(2);
    endtask

    task automatic test_alias();
        issue(0, 1'b1, 32'hABCD_0013, 32'hCAFEF00D, 4'hF);
        issue(0, 1'b0, 32'h7000_0012, 32'h0, 4'h0);
        step();
        n_cmp++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL alias_read: got dok %b rd %h want 1 cafef00d", data_ok[0], rdata[0]);
        end
        idle_steps(2);
    endtask

    task automatic test_read_then_write();
        issue(0, 1'b1, 32'h20, 32'h55667788, 4'hF);
        idle_steps(3);
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0);
        issue(0, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF);
        n_cmp++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== 32'h55667788) begin
            n_bad++; $display("FAIL raw_old_value: got dok %b rd %h want 1 55667788", data_ok[0], rdata[0]);
        end
        idle_steps(2);
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0);
        step();
        n_cmp++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL raw_new_value: got dok %b rd %h want 1 deadbeef", data_ok[0], rdata[0]);
        end
        idle_steps(2);
    endtask

    task automatic test_back_to_back();
        req[0] = 1'b1; wr[0] = 1'b1; wstrb[0] = 4'hF; size[0] = 2'd2;
        for (int j = 0; j < 6; j++) begin
            addr[0]  = 32'h40 + 32'(4 * j);
            wdata[0] = 32'h0B0B_0000 + 32'(j);
            n_cmp++;
            if (addr_ok[0] !== 1'b1) begin
                n_bad++; $display("FAIL b2b_aok beat %0d: got %b want 1", j, addr_ok[0]);
            end
            step();
        end
        req[0] = 1'b0;
        idle_steps(3);
    endtask

    task automatic test_backpressure();
        logic [31:0] bp_val [5];
        int  k_acc, k_rsp, acc_at_first;
        bit  prev_dok, resume_checked;
        for (int j = 0; j < 5; j++) begin
            bp_val[j] = $urandom();
            issue(1, 1'b1, 32'h100 + 32'(4 * j), bp_val[j], 4'hF);
        end
        idle_steps(6);
        k_acc = 0; k_rsp = 0; acc_at_first = -1; prev_dok = 0; resume_checked = 0;
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h100;
        for (int t = 0; t < 60 && k_rsp < 5; t++) begin
            step();
            if (prev_dok && !resume_checked) begin
                resume_checked = 1;
                n_cmp++;
                if (addr_ok[1] !== 1'b1) begin
                    n_bad++; $display("FAIL bp_resume: addr_ok got %b want 1", addr_ok[1]);
                end
            end
            if (acc_last[1]) begin
                k_acc++;
                if (k_acc < 5) addr[1] = 32'h100 + 32'(4 * k_acc);
                else req[1] = 1'b0;
                if (k_acc == 2) begin
                    n_cmp++;
                    if (addr_ok[1] !== 1'b0) begin
                        n_bad++; $display("FAIL bp_full: addr_ok got %b want 0", addr_ok[1]);
                    end
                end
            end
            prev_dok = 1'b0;
            if (data_ok[1] === 1'b1) begin
                if (acc_at_first < 0) acc_at_first = k_acc;
                n_cmp++;
                if (rdata[1] !== bp_val[k_rsp]) begin
                    n_bad++; $display("FAIL bp_order rsp %0d: got %h want %h", k_rsp, rdata[1], bp_val[k_rsp]);
                end
                k_rsp++;
                prev_dok = 1'b1;
            end
        end
        req[1] = 1'b0;
        n_cmp++;
        if (k_rsp != 5 || k_acc != 5) begin
            n_bad++; $display("FAIL bp_count: got %0d acc %0d rsp want 5 5", k_acc, k_rsp);
        end
        n_cmp++;
        if (acc_at_first != 2) begin
            n_bad++; $display("FAIL bp_acc_before_first: got %0d want 2", acc_at_first);
        end
        idle_steps(6);
    endtask

    task automatic test_reset_mid();
        int seen;
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h100; size[1] = 2'd2;
        step();
        addr[1] = 32'h104;
        step();
        req[1] = 1'b0;
        n_cmp++;
        if (pn[1] != 2) begin
            n_bad++; $display("FAIL rstmid_setup: pending got %0d want 2", pn[1]);
        end
        reset = 1'b1;
        idle_steps(2);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (addr_ok[1] !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_release_aok: got %b want 1", addr_ok[1]);
        end
        seen = 0;
        for (int t = 0; t < 8; t++) begin
            step();
            if (data_ok[1] === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++; $display("FAIL rstmid_ghost_resp: got %0d data_ok pulses want 0", seen);
        end
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        step();
        n_cmp++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL rstmid_store_kept: got dok %b rd %h want 1 cafef00d", data_ok[0], rdata[0]);
        end
        idle_steps(6);
    endtask

    task automatic test_random();
        int n_acc [2];
        int n_rsp [2];
        int n_low [2];
        logic [31:0] a;
        for (int w = 0; w < 32; w++) begin
            issue(0, 1'b1, 32'(4 * w), $urandom(), 4'hF);
            issue(1, 1'b1, 32'(4 * w), $urandom(), 4'hF);
        end
        idle_steps(6);
        for (int i = 0; i < 2; i++) begin
            n_acc[i] = 0; n_rsp[i] = 0; n_low[i] = 0;
        end
        for (int t = 0; t < 1000; t++) begin
            for (int i = 0; i < 2; i++) begin
                a        = $urandom();
                a[11:7]  = 5'd0;
                req[i]   = ($urandom_range(3, 0) != 0);
                wr[i]    = $urandom_range(1, 0) == 1;
                size[i]  = 2'($urandom_range(2, 0));
                wstrb[i] = 4'($urandom_range(15, 0));
                addr[i]  = a;
                wdata[i] = $urandom();
            end
            step();
            for (int i = 0; i < 2; i++) begin
                if (acc_last[i]) n_acc[i]++;
                if (data_ok[i] === 1'b1) n_rsp[i]++;
                if (addr_ok[i] === 1'b0) n_low[i]++;
            end
        end
        req[0] = 1'b0; req[1] = 1'b0;
        for (int t = 0; t < 8; t++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (data_ok[i] === 1'b1) n_rsp[i]++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (n_rsp[i] != n_acc[i]) begin
                n_bad++; $display("FAIL rand_resp_count dut%0d: got %0d want %0d", i, n_rsp[i], n_acc[i]);
            end
        end
`ifdef SRAM_RESP_RANDOM_STALL_EN
        n_cmp++;
        if (n_low[0] == 0) begin
            n_bad++; $display("FAIL rand_stall_seen dut0: got %0d low cycles want >0", n_low[0]);
        end
`endif
    endtask

    initial begin
        clk   = 1'b0;
        reset = 1'b1;
        cyc   = 0;
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; size[i] = 2'd0; wstrb[i] = 4'h0;
            addr[i] = 32'h0; wdata[i] = 32'h0;
            ph[i] = 0; pn[i] = 0; lfsr_m[i] = 16'hACE1; acc_last[i] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        test_reset();
        test_basic();
        test_strobe();
        test_alias();
        test_read_then_write();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
